// File: rtl/digital_mod_pkg.sv
// Shared modulation definitions for the modulator/demodulator pair.
// Holds the i_mod encodings, bits per symbol for each mode, the 16QAM/64QAM
// constellation levels and the hard-decision slicer thresholds.
package digital_mod_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned SR_W     = 6;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_QAM16 = 2'd2,
        MOD_QAM64 = 2'd3
    } mod_e;

    localparam logic signed [SAMPLE_W-1:0] SLICE_ZERO = 12'sd0;

    // 16QAM: levels +-81/+-243, decision points halfway between them
    localparam logic signed [SAMPLE_W-1:0] QAM16_LVL [4] = '{-12'sd243, -12'sd81, 12'sd81, 12'sd243};
    localparam logic signed [SAMPLE_W-1:0] QAM16_TH  = 12'sd162;

    // 64QAM: levels roughly 79 apart, thresholds listed lowest to highest
    localparam logic signed [SAMPLE_W-1:0] QAM64_LVL [8] = '{-12'sd277, -12'sd198, -12'sd119, -12'sd40,
                                                             12'sd40, 12'sd119, 12'sd198, 12'sd277};
    localparam logic signed [SAMPLE_W-1:0] QAM64_TH  [7] = '{-12'sd237, -12'sd158, -12'sd79, 12'sd0,
                                                             12'sd80, 12'sd158, 12'sd237};

    // Number of bits carried by one symbol in the given mode
    function automatic logic [CNT_W-1:0] bits_per_sym(input mod_e m);
        case (m)
            MOD_BPSK:  return CNT_W'(1);
            MOD_QPSK:  return CNT_W'(2);
            MOD_QAM16: return CNT_W'(4);
            default:   return CNT_W'(6);
        endcase
    endfunction

endpackage

// File: rtl/digital_demodulator_axis_slicer.sv
// axis_slicer: combinational hard-decision slicer for one axis (I or Q).
// Ports:
//   i_x    - signed axis sample
//   i_mod  - modulation mode
//   o_code - Gray-coded axis decision, right-aligned (1, 2 or 3 valid bits)
module axis_slicer
    import digital_mod_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] i_x,
    input  mod_e                       i_mod,
    output logic        [CODE_W-1:0]   o_code
);

    always_comb begin
        o_code = '0;
        case (i_mod)
            MOD_BPSK, MOD_QPSK: begin
                o_code = {2'b00, (i_x >= SLICE_ZERO)};
            end
            MOD_QAM16: begin
                if      (i_x >= QAM16_TH)   o_code = 3'b010;
                else if (i_x >= SLICE_ZERO) o_code = 3'b011;
                else if (i_x >= -QAM16_TH)  o_code = 3'b001;
                else                        o_code = 3'b000;
            end
            default: begin
                // Highest region first; each step down flips one code bit
                if      (i_x >= QAM64_TH[6]) o_code = 3'b100;
                else if (i_x >= QAM64_TH[5]) o_code = 3'b101;
                else if (i_x >= QAM64_TH[4]) o_code = 3'b111;
                else if (i_x >= QAM64_TH[3]) o_code = 3'b110;
                else if (i_x >= QAM64_TH[2]) o_code = 3'b010;
                else if (i_x >= QAM64_TH[1]) o_code = 3'b011;
                else if (i_x >= QAM64_TH[0]) o_code = 3'b001;
                else                         o_code = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/digital_demodulator.sv
// digital_demodulator: hard-decision I/Q demodulator with serial bit output.
// Ports:
//   i_clk, i_rst      - rising-edge clock, synchronous active-high reset
//   i_sym_vld, o_ready - symbol handshake (accepted when both high)
//   i_i, i_q          - signed I/Q samples
//   i_mod             - 0=BPSK, 1=QPSK, 2=16QAM, 3=64QAM
//   o_data_vld, o_data - serial demodulated bits, MSB first
//   o_ovf             - sticky: a symbol arrived while not ready and was dropped
module digital_demodulator
    import digital_mod_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sym_vld,
    input  logic [SAMPLE_W-1:0] i_i,
    input  logic [SAMPLE_W-1:0] i_q,
    input  logic [1:0]          i_mod,
    output logic                o_ready,
    output logic                o_data_vld,
    output logic                o_data,
    output logic                o_ovf
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SR_W-1:0]   r_sr;
    logic              r_ready;
    logic              r_data_vld;
    logic              r_data;
    logic              r_ovf;

    mod_e              w_mod;
    logic [CODE_W-1:0] w_code_i;
    logic [CODE_W-1:0] w_code_q;
    logic [SR_W-1:0]   w_load;
    logic [CNT_W-1:0]  w_bps;
    logic              w_accept;

    assign w_mod    = mod_e'(i_mod);
    assign w_bps    = bits_per_sym(w_mod);
    assign w_accept = i_sym_vld && r_ready;

    axis_slicer u_slice_i (
        .i_x    ($signed(i_i)),
        .i_mod  (w_mod),
        .o_code (w_code_i)
    );

    axis_slicer u_slice_q (
        .i_x    ($signed(i_q)),
        .i_mod  (w_mod),
        .o_code (w_code_q)
    );

    // Left-align the symbol's bits so the shift register always emits from bit 5
    always_comb begin
        w_load = '0;
        case (w_mod)
            MOD_BPSK:  w_load = {w_code_i[0], 5'b0};
            MOD_QPSK:  w_load = {w_code_i[0], w_code_q[0], 4'b0};
            MOD_QAM16: w_load = {w_code_i[1:0], w_code_q[1:0], 2'b0};
            default:   w_load = {w_code_i, w_code_q};
        endcase
    end

    // FSM, bit counter, shift register and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_ready    <= 1'b1;
            r_data_vld <= 1'b0;
            r_data     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (i_sym_vld && !r_ready) begin
                r_ovf <= 1'b1;
            end

            if (w_accept) begin
                // First bit goes straight to the output register
                r_state    <= ST_SHIFT;
                r_data_vld <= 1'b1;
                r_data     <= w_load[SR_W-1];
                r_sr       <= w_load << 1;
                r_cnt      <= w_bps - CNT_W'(1);
                r_ready    <= (w_bps == CNT_W'(1));
            end else if (r_state == ST_SHIFT && r_cnt != '0) begin
                r_data_vld <= 1'b1;
                r_data     <= r_sr[SR_W-1];
                r_sr       <= r_sr << 1;
                r_cnt      <= r_cnt - CNT_W'(1);
                // Ready again while the last bit is on the output
                r_ready    <= (r_cnt == CNT_W'(1));
            end else begin
                r_state    <= ST_IDLE;
                r_data_vld <= 1'b0;
                r_data     <= 1'b0;
                r_sr       <= '0;
                r_cnt      <= '0;
                r_ready    <= 1'b1;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_data_vld = r_data_vld;
    assign o_data     = r_data;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_digital_demodulator.sv
// Testbench for digital_demodulator: randomized and directed symbols, expected
// bits pushed into a scoreboard queue at acceptance, monitor compares at negedge.
module tb_digital_demodulator;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sym_vld;
    logic [11:0] i_i;
    logic [11:0] i_q;
    logic [1:0]  i_mod;
    logic        o_ready;
    logic        o_data_vld;
    logic        o_data;
    logic        o_ovf;

    digital_demodulator dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sym_vld  (i_sym_vld),
        .i_i        (i_i),
        .i_q        (i_q),
        .i_mod      (i_mod),
        .o_ready    (o_ready),
        .o_data_vld (o_data_vld),
        .o_data     (o_data),
        .o_ovf      (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];
    int m_left = 0;      // bits of the current symbol not yet shown on o_data
    bit m_ovf  = 1'b0;
    bit mon_en = 1'b0;
    int run_len = 0;
    int max_run = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Region index = number of thresholds reached; axis code is its Gray code
    function automatic int code16(input int x);
        int r = 0;
        if (x >= -162) r++;
        if (x >= 0)    r++;
        if (x >= 162)  r++;
        return r ^ (r >> 1);
    endfunction

    function automatic int code64(input int x);
        int th[7] = '{-237, -158, -79, 0, 80, 158, 237};
        int r = 0;
        foreach (th[k]) if (x >= th[k]) r++;
        return r ^ (r >> 1);
    endfunction

    function automatic int bps(input int mod);
        case (mod)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 6;
        endcase
    endfunction

    task automatic push_bits(input int x, input int y, input int mod);
        int cx, cy;
        case (mod)
            0: exp_q.push_back(x >= 0);
            1: begin exp_q.push_back(x >= 0); exp_q.push_back(y >= 0); end
            2: begin
                cx = code16(x); cy = code16(y);
                for (int k = 1; k >= 0; k--) exp_q.push_back(cx[k]);
                for (int k = 1; k >= 0; k--) exp_q.push_back(cy[k]);
            end
            default: begin
                cx = code64(x); cy = code64(y);
                for (int k = 2; k >= 0; k--) exp_q.push_back(cx[k]);
                for (int k = 2; k >= 0; k--) exp_q.push_back(cy[k]);
            end
        endcase
    endtask

    // One clock cycle of stimulus; model advances at the rising edge
    task automatic cyc(input bit rst, input bit vld, input int x, input int y, input int mod);
        bit acc;
        bit rdy;
        i_rst     = rst;
        i_sym_vld = vld;
        i_i       = 12'(x);
        i_q       = 12'(y);
        i_mod     = 2'(mod);
        rdy = (m_left <= 1);
        acc = !rst && vld && rdy;
        if (acc) push_bits(x, y, mod);
        @(posedge i_clk);
        if (rst) begin
            m_left = 0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            if (vld && !rdy) m_ovf = 1'b1;
            if (acc)              m_left = bps(mod);
            else if (m_left > 0)  m_left--;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0, int'($urandom_range(0, 3)));
    endtask

    task automatic sym(input int x, input int y, input int mod);
        cyc(1'b0, 1'b1, x, y, mod);
    endtask

    // Monitor: compare DUT outputs against the model every cycle
    always @(negedge i_clk) begin
        if (mon_en) begin
            check("data_vld", int'(o_data_vld), int'(m_left > 0));
            if (o_data_vld) begin
                check("queue_has_bit", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("data", int'(o_data), int'(exp_q.pop_front()));
            end else begin
                check("data_when_idle", int'(o_data), 0);
            end
            check("ready", int'(o_ready), int'(m_left <= 1));
            check("ovf", int'(o_ovf), int'(m_ovf));
            run_len = o_data_vld ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    int bnd[25] = '{-238, -237, -236, -163, -162, -161, -159, -158, -80, -79, -78, -1, 0,
                    1, 79, 80, 81, 157, 158, 161, 162, 236, 237, 2047, -2048};

    function automatic int rnd_sample();
        if ($urandom_range(0, 9) < 3) return bnd[$urandom_range(0, 24)];
        return int'($urandom_range(0, 800)) - 400;
    endfunction

    initial begin
        cyc(1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 100, 100, 3);
        mon_en = 1'b1;
        idle(2);

        // BPSK: -256 -> 0, 256 -> 1, 0 -> 1
        sym(-256, 0, 0); sym(256, 0, 0); sym(0, 0, 0); idle(3);
        // QPSK: 1,0
        sym(181, -181, 1); idle(3);
        // 64QAM: 111 000
        sym(119, -277, 3); idle(7);
        // 64QAM boundaries 80 / 79
        sym(80, 0, 3); idle(7);
        sym(79, 0, 3); idle(7);
        // 16QAM boundaries 162 / 161
        sym(162, 0, 2); idle(5);
        sym(161, 0, 2); idle(5);

        // Back-to-back 16QAM: second symbol offered on the last-bit cycle
        max_run = 0;
        sym(200, -50, 2); idle(3); sym(-300, 30, 2); idle(5);
        check("b2b_16qam_run", max_run, 8);

        // Drop while busy; i_mod changed mid-symbol must not matter
        sym(-100, 200, 3); sym(50, 50, 0); cyc(1'b0, 1'b0, 0, 0, 0); idle(6);
        check("ovf_sticky", int'(o_ovf), 1);

        // Reset on bit 3 of a 64QAM symbol
        sym(250, -250, 3); idle(2);
        cyc(1'b1, 1'b0, 0, 0, 0);
        check("rst_vld", int'(o_data_vld), 0);
        check("rst_ready", int'(o_ready), 1);
        idle(3);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0)
                cyc(1'b1, 1'($urandom_range(0, 1)), rnd_sample(), rnd_sample(), int'($urandom_range(0, 3)));
            else
                cyc(1'b0, ($urandom_range(0, 9) < 6), rnd_sample(), rnd_sample(), int'($urandom_range(0, 3)));
        end
        idle(10);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
